i2c_tx_queue: RTL and testbench

//  Upstream command stage for i2c_master. Buffers {7-bit addr, r/w, 8-bit data} transactions in a FIFO.

---
 rtl/i2c_tx_queue_if.sv | 46 ++++
 rtl/i2c_tx_queue.sv | 219 +++++++++++++++++++++
 tb/tb_i2c_tx_queue.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_tx_queue_if.sv
// -----------------------------------------------------------------------------
// i2c_tx_queue_if
//   Bundles the signals of i2c_tx_queue: the upstream push handshake, the
//   command outputs towards i2c_master, the scl/sda bus monitors and the
//   status strobes.
//   Modports:
//     slave  - the queue itself (accepts pushes, drives i2c_master commands)
//     master - the upstream producer / bus environment
//   Signals:
//     wr_valid/wr_ready/wr_addr[6:0]/wr_rw/wr_data[7:0]  push handshake
//     addr2send[6:0]/r_or_w/data2send[7:0]/pulse         command to i2c_master
//     scl_mon/sda_mon                                    bus monitor inputs
//     busy/done/level/err_timeout                        status
//   DEPTH must match the DEPTH of the attached i2c_tx_queue (sizes level).
// -----------------------------------------------------------------------------
interface i2c_tx_queue_if #(
  parameter int DEPTH = 4
);
  logic                     wr_valid;
  logic                     wr_ready;
  logic [6:0]               wr_addr;
  logic                     wr_rw;
  logic [7:0]               wr_data;
  logic [6:0]               addr2send;
  logic                     r_or_w;
  logic [7:0]               data2send;
  logic                     pulse;
  logic                     scl_mon;
  logic                     sda_mon;
  logic                     busy;
  logic                     done;
  logic [$clog2(DEPTH):0]   level;
  logic                     err_timeout;

  modport slave (
    input  wr_valid, wr_addr, wr_rw, wr_data, scl_mon, sda_mon,
    output wr_ready, addr2send, r_or_w, data2send, pulse,
           busy, done, level, err_timeout
  );

  modport master (
    output wr_valid, wr_addr, wr_rw, wr_data, scl_mon, sda_mon,
    input  wr_ready, addr2send, r_or_w, data2send, pulse,
           busy, done, level, err_timeout
  );
endinterface

// File: rtl/i2c_tx_queue.sv
// -----------------------------------------------------------------------------
// i2c_tx_queue
//   Upstream command stage for i2c_master. Buffers {addr, r/w, data}
//   transactions in a FIFO and launches them one at a time with a 1-cycle
//   pulse. Since i2c_master has no busy/done output, completion is tracked by
//   watching START/STOP on the bus; the head entry is popped at STOP.
//   A launch only happens after GAP_CYCLES consecutive idle bus samples.
//   Ports:
//     clk    - system clock
//     reset  - asynchronous reset, active-high
//     q      - i2c_tx_queue_if.slave (push handshake, i2c_master command,
//              bus monitors, busy/done/level/err_timeout)
//   Optional feature macro: I2C_TXQ_TIMEOUT_EN
//     When defined, WAIT_START/WAIT_STOP give up after TIMEOUT_CYCLES, drop
//     the head entry and strobe err_timeout. Otherwise they wait forever and
//     err_timeout is tied low.
// -----------------------------------------------------------------------------
module i2c_tx_queue #(
  parameter int DEPTH          = 4,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic           clk,
  input  logic           reset,
  i2c_tx_queue_if.slave  q
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int GW = $clog2(GAP_CYCLES + 1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || GAP_CYCLES < 1 ||
      TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("i2c_tx_queue: illegal parameter set");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_START,
    S_WAIT_STOP
  } state_t;

  state_t          state_q, state_d;

  // ---------------------------------------------------------------- monitor
  logic            scl_s_q, sda_s_q, sda_p_q;
  logic            start_det, stop_det;
  logic [GW-1:0]   gap_q;
  logic            gap_ok;

  // Monitor registers reset to the idle-bus level so that reset release on an
  // idle bus produces no spurious edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_s_q <= 1'b1;
      sda_s_q <= 1'b1;
      sda_p_q <= 1'b1;
    end else begin
      scl_s_q <= q.scl_mon;
      sda_s_q <= (q.sda_mon === 1'b0) ? 1'b0 : 1'b1;
      sda_p_q <= sda_s_q;
    end
  end

  assign start_det = scl_s_q &  sda_p_q & ~sda_s_q;
  assign stop_det  = scl_s_q & ~sda_p_q &  sda_s_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gap_q <= '0;
    end else if (!(scl_s_q && sda_s_q)) begin
      gap_q <= '0;
    end else if (gap_q != GW'(GAP_CYCLES)) begin
      gap_q <= gap_q + GW'(1);
    end
  end

  assign gap_ok = (gap_q == GW'(GAP_CYCLES));

  // ------------------------------------------------------------------- FIFO
  logic [15:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]   count_q, count_d;
  logic            full, empty, push, pop;
  logic [15:0]     head;

  assign full  = (count_q == LW'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = q.wr_valid & ~full;
  assign head  = mem[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= {q.wr_addr, q.wr_rw, q.wr_data};
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + LW'(1);
      2'b01:   count_d = count_q - LW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // ---------------------------------------------------------------- timeout
  logic tmo_hit;

`ifdef I2C_TXQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q;

  // Cleared on every state change, so each wait state gets a fresh budget.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_q <= '0;
    end else if (state_d != state_q) begin
      tmo_q <= '0;
    end else if (state_q == S_WAIT_START || state_q == S_WAIT_STOP) begin
      tmo_q <= tmo_q + TW'(1);
    end
  end

  assign tmo_hit = (tmo_q == TW'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  // -------------------------------------------------------------------- FSM
  logic launch, done_c, tmo_c;

  always_comb begin
    state_d = state_q;
    launch  = 1'b0;
    pop     = 1'b0;
    done_c  = 1'b0;
    tmo_c   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty && gap_ok) begin
          state_d = S_LAUNCH;
          launch  = 1'b1;
        end
      end
      S_LAUNCH: begin
        state_d = S_WAIT_START;
      end
      S_WAIT_START: begin
        if (start_det) begin
          state_d = S_WAIT_STOP;
        end else if (tmo_hit) begin
          state_d = S_IDLE;
          pop     = 1'b1;
          tmo_c   = 1'b1;
        end
      end
      S_WAIT_STOP: begin
        if (stop_det) begin
          state_d = S_IDLE;
          pop     = 1'b1;
          done_c  = 1'b1;
        end else if (tmo_hit) begin
          state_d = S_IDLE;
          pop     = 1'b1;
          tmo_c   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Command registers load on the IDLE->LAUNCH transition so that the fields
  // and the pulse are both visible during the LAUNCH cycle.
  logic [6:0] addr_q;
  logic       rw_q;
  logic [7:0] data_q;
  logic       pulse_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      data_q  <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pulse_q <= launch;
      if (launch) begin
        addr_q <= head[15:9];
        rw_q   <= head[8];
        data_q <= head[7:0];
      end
    end
  end

  assign q.wr_ready    = ~full;
  assign q.addr2send   = addr_q;
  assign q.r_or_w      = rw_q;
  assign q.data2send   = data_q;
  assign q.pulse       = pulse_q;
  assign q.busy        = (state_q != S_IDLE);
  assign q.done        = done_c;
  assign q.level       = count_q;
  assign q.err_timeout = tmo_c;

endmodule

// File: tb/tb_i2c_tx_queue.sv
module tb_i2c_tx_queue;
  localparam int DEPTH = 4;
  localparam int GAP   = 16;
  localparam int TMO   = 64;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  i2c_tx_queue_if #(.DEPTH(DEPTH)) bus ();

  i2c_tx_queue #(.DEPTH(DEPTH), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .q     (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int          t;
    logic [15:0] f;
  } lrec_t;

  typedef struct {
    logic [15:0] e;
    int          exp_level;
    bit          exp_ready;
  } vec_t;

  lrec_t       launch_q[$];
  logic [15:0] sb[$];
  int          model_level = 0;
  int          last_stop   = -1000;
  int          pulse_cnt = 0, done_cnt = 0, err_cnt = 0;
  bit          prev_pulse = 1'b0;

  // Captures every launch so none is missed while the stimulus is busy.
  always @(negedge clk) begin
    if (bus.pulse) begin
      pulse_cnt++;
      launch_q.push_back('{cyc, {bus.addr2send, bus.r_or_w, bus.data2send}});
      checks++;
      if (prev_pulse) begin
        errors++;
        $display("FAIL pulse_single: actual high 2 cycles, required 1");
      end
    end
    prev_pulse = bus.pulse;
    if (bus.done) done_cnt++;
    if (bus.err_timeout) err_cnt++;
  end

  function automatic logic [15:0] pk(input logic [6:0] a, input logic rw, input logic [7:0] d);
    return {a, rw, d};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [15:0] e);
    bus.wr_valid = 1'b1;
    {bus.wr_addr, bus.wr_rw, bus.wr_data} = e;
    step();
    bus.wr_valid = 1'b0;
    if (model_level < DEPTH) begin
      sb.push_back(e);
      model_level++;
    end
  endtask

  task automatic wait_pulse(output int t, output logic [15:0] f, output bit ok);
    lrec_t r;
    logic [15:0] want;
    ok = 1'b0;
    t  = 0;
    f  = '0;
    for (int i = 0; i < 400; i++) begin
      if (launch_q.size() != 0) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL launch_wait: actual no pulse in 400 cycles, required a pulse");
      return;
    end
    r = launch_q.pop_front();
    t = r.t;
    f = r.f;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL launch_expected: actual pulse with 0x%0h, required none", r.f);
      return;
    end
    want = sb.pop_front();
    chk("launch_fields", r.f, want);
    checks++;
    if (r.t - last_stop < GAP) begin
      errors++;
      $display("FAIL launch_gap: actual %0d cycles, required >= %0d", r.t - last_stop, GAP);
    end
  endtask

  // Emulates i2c_master on the bus: START, 8 data bits + ack, STOP.
  task automatic do_frame(input logic [15:0] hold, input bit do_push, input logic [15:0] pe);
    chk("busy_in_flight", bus.busy, 1);
    bus.sda_mon = 1'b0;
    step(2);
    bus.scl_mon = 1'b0;
    step();
    for (int i = 8; i >= 0; i--) begin
      bus.sda_mon = (i == 0) ? 1'b0 : hold[i-1];
      step();
      bus.scl_mon = 1'b1;
      step();
      bus.scl_mon = 1'b0;
      step();
    end
    chk("fields_held", {bus.addr2send, bus.r_or_w, bus.data2send}, hold);
    bus.sda_mon = 1'b0;
    step();
    bus.scl_mon = 1'b1;
    step(2);
    bus.sda_mon = 1'b1;
    last_stop = cyc;
    step();
    chk("done_after_stop", bus.done, 1);
    if (do_push) begin
      bus.wr_valid = 1'b1;
      {bus.wr_addr, bus.wr_rw, bus.wr_data} = pe;
    end
    step();
    bus.wr_valid = 1'b0;
    if (do_push) sb.push_back(pe);
    else model_level--;
    chk("done_one_cycle", bus.done, 0);
    chk("idle_after_done", bus.busy, 0);
    chk("level_after_done", bus.level, model_level);
  endtask

  task automatic txn(input bit do_push, input logic [15:0] pe);
    int t;
    logic [15:0] f;
    bit ok;
    wait_pulse(t, f, ok);
    if (ok) do_frame(f, do_push, pe);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t v[5];
    logic [15:0] t3[3];
    int p0, d0, t;
    logic [15:0] f;
    bit ok;

    bus.wr_valid = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_rw    = 1'b0;
    bus.wr_data  = '0;
    bus.scl_mon  = 1'b1;
    bus.sda_mon  = 1'b1;
    reset        = 1'b1;

    // Reset state
    step(3);
    chk("rst_busy", bus.busy, 0);
    reset = 1'b0;
    step(3);
    chk("rst_pulse", bus.pulse, 0);
    chk("rst_busy2", bus.busy, 0);
    chk("rst_level", bus.level, 0);
    chk("rst_ready", bus.wr_ready, 1);
    chk("rst_addr", bus.addr2send, 0);
    chk("rst_data", bus.data2send, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err_timeout, 0);

    // Single write transaction
    p0 = pulse_cnt;
    push(pk(7'h50, 1'b0, 8'hA5));
    txn(1'b0, '0);
    chk("single_pulse_count", pulse_cnt - p0, 1);

    // Three back-to-back entries
    t3[0] = pk(7'h50, 1'b0, 8'h11);
    t3[1] = pk(7'h50, 1'b0, 8'h22);
    t3[2] = pk(7'h50, 1'b0, 8'h33);
    p0 = pulse_cnt;
    d0 = done_cnt;
    for (int i = 0; i < 3; i++) push(t3[i]);
    for (int i = 0; i < 3; i++) txn(1'b0, '0);
    chk("three_pulses", pulse_cnt - p0, 3);
    chk("three_dones", done_cnt - d0, 3);

    // Overfill while the bus is held busy
    v[0] = '{pk(7'h21, 1'b0, 8'h01), 1, 1'b1};
    v[1] = '{pk(7'h22, 1'b1, 8'h02), 2, 1'b1};
    v[2] = '{pk(7'h23, 1'b0, 8'h03), 3, 1'b1};
    v[3] = '{pk(7'h24, 1'b1, 8'h04), 4, 1'b0};
    v[4] = '{pk(7'h25, 1'b0, 8'h05), 4, 1'b0};
    bus.sda_mon = 1'b0;
    step(2);
    for (int i = 0; i < 5; i++) begin
      push(v[i].e);
      chk("fill_level", bus.level, v[i].exp_level);
      chk("fill_ready", bus.wr_ready, v[i].exp_ready);
      chk("fill_no_launch", bus.busy, 0);
    end
    bus.sda_mon = 1'b1;
    last_stop = cyc;
    for (int i = 0; i < 4; i++) txn(1'b0, '0);
    chk("fill_drained", bus.level, 0);

    // Push on the same cycle as done with level 2
    bus.sda_mon = 1'b0;
    step(2);
    push(pk(7'h31, 1'b0, 8'hA1));
    push(pk(7'h32, 1'b1, 8'hB2));
    chk("pp_level_pre", bus.level, 2);
    bus.sda_mon = 1'b1;
    last_stop = cyc;
    txn(1'b1, pk(7'h33, 1'b0, 8'hC3));
    txn(1'b0, '0);
    txn(1'b0, '0);
    chk("pp_drained", bus.level, 0);

`ifdef I2C_TXQ_TIMEOUT_EN
    // No START after the pulse: the entry is dropped after TMO cycles
    begin
      bit found;
      d0 = done_cnt;
      push(pk(7'h44, 1'b0, 8'h5A));
      wait_pulse(t, f, ok);
      found = 1'b0;
      for (int i = 0; i < 200; i++) begin
        step();
        if (bus.err_timeout) begin
          found = 1'b1;
          break;
        end
      end
      chk("tmo_fired", found, 1);
      chk("tmo_latency", (cyc - t >= TMO - 1) && (cyc - t <= TMO + 1), 1);
      model_level--;
      step();
      chk("tmo_one_cycle", bus.err_timeout, 0);
      chk("tmo_level", bus.level, model_level);
      chk("tmo_idle", bus.busy, 0);
      chk("tmo_no_done", done_cnt - d0, 0);
    end
`else
    // No START after the pulse: the queue keeps waiting
    push(pk(7'h44, 1'b0, 8'h5A));
    wait_pulse(t, f, ok);
    step(200);
    chk("stall_busy", bus.busy, 1);
    chk("stall_no_err", err_cnt, 0);
    chk("stall_level", bus.level, 1);
    if (ok) do_frame(f, 1'b0, '0);
`endif

    // Reset asserted in WAIT_STOP
    push(pk(7'h55, 1'b1, 8'h66));
    wait_pulse(t, f, ok);
    bus.sda_mon = 1'b0;
    step(3);
    chk("mid_busy", bus.busy, 1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_level", bus.level, 0);
    chk("mid_rst_ready", bus.wr_ready, 1);
    chk("mid_rst_fields", {bus.addr2send, bus.r_or_w, bus.data2send}, 0);
    chk("mid_rst_pulse", bus.pulse, 0);
    step(2);
    reset = 1'b0;
    sb.delete();
    model_level = 0;
    p0 = pulse_cnt;
    d0 = done_cnt;
    step();
    bus.sda_mon = 1'b1;
    step(GAP + 10);
    chk("mid_no_pulse", pulse_cnt - p0, 0);
    chk("mid_no_done", done_cnt - d0, 0);
    chk("mid_idle", bus.busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
